// File: rtl/ram_initiator_pkg.sv
// ---------------------------------------------------------------------------
// ram_initiator_pkg
// Shared types and defaults for the RAM bus-master front end.
//   - default widths for data, word address and burst length
//   - state encoding of the initiator FSM (fixed 3-bit codes so the values
//     stay stable for any logic that decodes them as plain vectors)
//   - request bundle {we, addr, len} at the default widths
// ---------------------------------------------------------------------------
package ram_initiator_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_ACCESS = 3'd1;
    localparam logic [2:0] S_RD_RESP   = 3'd2;
    localparam logic [2:0] S_WR_DATA   = 3'd3;
    localparam logic [2:0] S_WR_COMMIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        RD_ACCESS = S_RD_ACCESS,
        RD_RESP   = S_RD_RESP,
        WR_DATA   = S_WR_DATA,
        WR_COMMIT = S_WR_COMMIT
    } ram_init_state_e;

    typedef struct packed {
        logic                      we;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [LEN_WIDTH_DEF-1:0]  len;
    } ram_init_req_t;

endpackage

// File: rtl/ram_burst_ctr.sv
// ---------------------------------------------------------------------------
// ram_burst_ctr
// Burst address register and remaining-beat down-counter.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture load_addr / load_len (start of a burst)
//   step               : advance to the next beat (addr+1, cnt-1)
//   load_addr/load_len : first word address and beats-minus-one
//   addr               : current beat address
//   last               : current beat is the final one (cnt == 0)
//   bound_err          : load_addr+load_len runs past the top of the address
//                        space (carry out of the ADDR_WIDTH+1 bit sum)
// ---------------------------------------------------------------------------
module ram_burst_ctr #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  bound_err
);

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  cnt_reg;
    logic [ADDR_WIDTH:0]   end_sum;

    // One extra bit so an overrun shows up as the carry instead of wrapping.
    assign end_sum   = {1'b0, load_addr} + {{(ADDR_WIDTH + 1 - LEN_WIDTH){1'b0}}, load_len};
    assign bound_err = end_sum[ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            addr_reg <= load_addr;
            cnt_reg  <= load_len;
        end else if (step) begin
            addr_reg <= addr_reg + 1'b1;   // modulo 2**ADDR_WIDTH
            cnt_reg  <= cnt_reg - 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = (cnt_reg == '0);

endmodule

// File: rtl/ram_initiator.sv
// ---------------------------------------------------------------------------
// ram_initiator
// Bus master that runs read/write bursts against a single-port RAM with
// combinational read data.
//   req_*   : burst request (valid/ready), accepted only in IDLE
//   req_err : one-cycle reject pulse for bursts that overrun the address
//             space; only active when RAM_INITIATOR_BOUND_CHECK_EN is
//             defined, tied low otherwise (bursts then wrap silently)
//   wdata_* : write beat channel (valid/ready)
//   rsp_*   : read beat channel, data held stable until rsp_ready
//   wr_done : one-cycle pulse in the first IDLE cycle after a write burst
//   busy    : unit is not IDLE
//   mem_*   : RAM addr / wr_data / wr_en, mem_rd_data from RAM
// Each read beat takes RD_ACCESS (sample RAM into rdata_reg) then RD_RESP;
// each write beat takes WR_DATA (capture wdata) then WR_COMMIT (wr_en high).
// ---------------------------------------------------------------------------
module ram_initiator
    import ram_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  req_err,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  wr_done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

`ifdef RAM_INITIATOR_BOUND_CHECK_EN
    localparam bit BOUND_CHECK_EN = 1'b1;
`else
    localparam bit BOUND_CHECK_EN = 1'b0;
`endif

    ram_init_state_e       state_reg, state_next;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  wr_done_reg;
    logic                  req_fire;
    logic                  req_reject;
    logic                  ctr_load;
    logic                  ctr_step;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  cnt_last;
    logic                  bound_err;

    ram_burst_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .step      (ctr_step),
        .load_addr (req_addr),
        .load_len  (req_len),
        .addr      (addr_q),
        .last      (cnt_last),
        .bound_err (bound_err)
    );

    assign req_fire   = (state_reg == IDLE) && req_valid;
    // A rejected request still handshakes; it just never leaves IDLE.
    assign req_reject = req_fire && bound_err && BOUND_CHECK_EN;

    always_comb begin
        state_next = state_reg;
        ctr_load   = 1'b0;
        ctr_step   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_fire && !req_reject) begin
                    ctr_load   = 1'b1;
                    state_next = req_we ? WR_DATA : RD_ACCESS;
                end
            end
            RD_ACCESS: state_next = RD_RESP;
            RD_RESP: begin
                if (rsp_ready) begin
                    if (cnt_last) begin
                        state_next = IDLE;
                    end else begin
                        ctr_step   = 1'b1;
                        state_next = RD_ACCESS;
                    end
                end
            end
            WR_DATA: begin
                if (wdata_valid) state_next = WR_COMMIT;
            end
            WR_COMMIT: begin
                if (cnt_last) begin
                    state_next = IDLE;
                end else begin
                    ctr_step   = 1'b1;
                    state_next = WR_DATA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rdata_reg   <= '0;
            wdata_reg   <= '0;
            wr_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_done_reg <= (state_reg == WR_COMMIT) && cnt_last;
            if (state_reg == RD_ACCESS) rdata_reg <= mem_rd_data;
            if ((state_reg == WR_DATA) && wdata_valid) wdata_reg <= wdata;
        end
    end

`ifdef RAM_INITIATOR_BOUND_CHECK_EN
    logic req_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_err_reg <= 1'b0;
        else        req_err_reg <= req_reject;
    end

    assign req_err = req_err_reg;
`else
    assign req_err = 1'b0;
`endif

    // Control outputs decode the registered state, so an asynchronous reset
    // drops mem_wr_en and rsp_valid immediately.
    assign req_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign wdata_ready = (state_reg == WR_DATA);
    assign rsp_valid   = (state_reg == RD_RESP);
    assign rsp_data    = rdata_reg;
    assign rsp_last    = (state_reg == RD_RESP) && cnt_last;
    assign wr_done     = wr_done_reg;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_reg;
    assign mem_wr_en   = (state_reg == WR_COMMIT);

endmodule

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Bus-master front end that drives the single-port RAM on behalf of the CPU datapath or a DMA-style client.
- Accepts read or write burst requests over a valid/ready handshake and generates the RAM's addr, wr_data and wr_en each beat.
- Registers combinational RAM read data into a memory data register and returns it on a back-pressured response channel.
- Sits between the multicycle control/datapath and the RAM.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 32, RAM word-address width; address space is 2**ADDR_WIDTH words.
- LEN_WIDTH, 4, burst length field width; burst beats = req_len+1, so 1..2**LEN_WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1 = write burst, 0 = read burst.
- req_addr  input  ADDR_WIDTH  first word address.
- req_len  input  LEN_WIDTH  beats minus one.
- req_err  output  1  one-cycle reject pulse; driven only with the optional feature, tied 0 otherwise.
- wdata_valid  input  1  write beat data present.
- wdata_ready  output  1  unit accepts a write beat.
- wdata  input  DATA_WIDTH  write beat data.
- rsp_valid  output  1  read beat available.
- rsp_ready  input  1  consumer accepts the read beat.
- rsp_data  output  DATA_WIDTH  read beat data, held stable while rsp_valid.
- rsp_last  output  1  final read beat of the burst.
- wr_done  output  1  one-cycle pulse after the last write beat commits.
- busy  output  1  state != IDLE.
- mem_addr  output  ADDR_WIDTH  to RAM addr.
- mem_wr_data  output  DATA_WIDTH  to RAM wr_data.
- mem_wr_en  output  1  to RAM wr_en.
- mem_rd_data  input  DATA_WIDTH  from RAM rd_data, combinational from addr.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; addr_q, cnt_q, rdata_q and wdata_q = 0; all outputs 0 except req_ready=1.
- Reset mid-burst immediately deasserts mem_wr_en and rsp_valid. The partial burst is abandoned and no wr_done is issued.
- States: IDLE, RD_ACCESS, RD_RESP, WR_DATA, WR_COMMIT.
- IDLE: on req_valid&&req_ready, capture addr_q=req_addr and cnt_q=req_len. Go to WR_DATA if req_we, else RD_ACCESS. A request is accepted only in IDLE.
- RD_ACCESS, exactly one cycle: mem_addr=addr_q. Sample rdata_q<=mem_rd_data, go to RD_RESP.
- RD_RESP: rsp_valid=1, rsp_data=rdata_q, rsp_last=(cnt_q==0). Hold until rsp_ready.
  - On handshake with cnt_q==0: go to IDLE.
  - On handshake otherwise: addr_q<=addr_q+1, cnt_q<=cnt_q-1, go to RD_ACCESS.
- Read latency: first rsp_valid 2 cycles after request acceptance. Throughput is 1 beat per 2 cycles with rsp_ready held high.
- WR_DATA: wdata_ready=1. On wdata_valid, capture wdata_q<=wdata and go to WR_COMMIT.
- WR_COMMIT, exactly one cycle: mem_wr_en=1, mem_addr=addr_q, mem_wr_data=wdata_q.
  - If cnt_q==0: go to IDLE and pulse wr_done in the next cycle, the first IDLE cycle.
  - Otherwise: addr_q<=addr_q+1, cnt_q<=cnt_q-1, go to WR_DATA.
- mem_wr_en is high only in WR_COMMIT. mem_addr=addr_q in all states.
- Address arithmetic is modulo 2**ADDR_WIDTH, so the address wraps from max to 0.
- A new request may be accepted in the same cycle wr_done pulses.

Optional Feature:
- Macro: RAM_INITIATOR_BOUND_CHECK_EN.
- When defined:
  - A request with req_addr+req_len > 2**ADDR_WIDTH-1 (computed at ADDR_WIDTH+1 bits) is rejected.
  - On reject, the handshake still completes (req_ready=1), req_err pulses the next cycle, and the state stays IDLE.
  - No RAM access and no wdata is consumed.
- When undefined: req_err is tied 0 and bursts wrap silently.

Decomposition:
- Package ram_initiator_pkg holds:
  - the state enum typedef ram_init_state_e;
  - the request struct typedef ram_init_req_t {we, addr, len};
  - localparam defaults for the widths.
- One sub-module, ram_burst_ctr: loadable address register and down-counter with increment/decrement enable, last flag, and the bound-check compare.

Test Plan:
- Single read: preload RAM[0x10]=0xDEADBEEF; request read addr 0x10, len 0 -> rsp_valid 2 cycles later with data 0xDEADBEEF and rsp_last=1; unit returns to IDLE.
- Write burst: write addr 0x20, len 3, data 0x1..0x4 with wdata_valid gaps -> RAM[0x20..0x23]=1,2,3,4, one mem_wr_en per beat, a single wr_done pulse.
- Read back-pressure: read addr 0x20, len 3, with rsp_ready low for 5 cycles on beat 1 -> rsp_data held stable, no address advance, beats 1,2,3,4 delivered in order.
- Wrap: read addr 2**ADDR_WIDTH-2, len 3 (feature off) -> addresses max-1, max, 0, 1. With the feature on -> req_err pulse, no rsp_valid.
- Reset mid-write: rst_n low during the WR_DATA of beat 2 of 4 -> mem_wr_en 0 immediately, req_ready=1, no wr_done; the next request is served normally.
- req_valid held during a busy burst -> ignored until IDLE, then accepted exactly once.
